// File: rtl/ysyx_25040111_muldiv.sv
// Multi-cycle RV32M/RV64M multiply/divide unit for the EXU.
// Multiplies with radix-2 shift-add and divides with restoring shift-subtract.
// Each operation runs WIDTH iterations on operand magnitudes; the sign is fixed up afterwards.
// Divide-by-zero and signed overflow bypass the iterations.
//
// Handshake contract:
// - A request is taken on a rising edge where in_valid && in_ready && !flush.
// - A result is taken on a rising edge where out_valid && out_ready.
// - in_ready is high only in IDLE, and out_valid is high only in DONE.
// - A result stays stable in DONE until it is taken.
// - flush (and reset) return the unit to IDLE on the next edge and drop any
//   operation in flight.
module ysyx_25040111_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] var1,
  input  logic [WIDTH-1:0] var2,
  input  logic [2:0]       opt,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state_q, state_d;
  logic [2:0]         opt_q, opt_d;
  logic               neg_q, neg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;   // {hi, lo}: product, or {remainder, quotient}
  logic [WIDTH-1:0]   opb_q, opb_d;   // |var2|: multiplicand or divisor
  logic [WIDTH-1:0]   res_q, res_d;

  logic             accept, is_div, a_signed, b_signed, neg_a, neg_b;
  logic             div_zero, div_ovf, fast;
  logic [WIDTH-1:0] abs_a, abs_b, fast_res;

  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH:0]     mul_sum, div_sh;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] acc_step, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fin_res;

  // Decode the live request: operand signedness, magnitudes, fast-path results.
  always_comb begin
    accept   = in_valid && in_ready && !flush;
    is_div   = opt[2];
    a_signed = is_div ? ~opt[0] : (opt[1:0] != 2'b11);
    b_signed = is_div ? ~opt[0] : ~opt[1];
    neg_a    = a_signed & var1[WIDTH-1];
    neg_b    = b_signed & var2[WIDTH-1];
    abs_a    = neg_a ? -var1 : var1;
    abs_b    = neg_b ? -var2 : var2;
    div_zero = is_div && (var2 == '0);
    div_ovf  = is_div && !opt[0] && (var1 == MOST_NEG) && (var2 == '1);
    fast     = div_zero || div_ovf;
    if (div_zero) fast_res = opt[1] ? var1 : '1;
    else          fast_res = opt[1] ? '0 : var1;
  end

  // One iteration of shift-add or shift-subtract, followed by sign fix-up and result selection.
  always_comb begin
    hi       = acc_q[2*WIDTH-1:WIDTH];
    lo       = acc_q[WIDTH-1:0];
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opb_q} : '0);
    div_sh   = {hi, lo[WIDTH-1]};
    div_ge   = div_sh >= {1'b0, opb_q};
    // When div_ge holds the difference is below 2^WIDTH, so the low bits are exact.
    div_diff = div_sh[WIDTH-1:0] - opb_q;
    if (opt_q[2]) begin
      if (div_ge) acc_step = {div_diff, lo[WIDTH-2:0], 1'b1};
      else        acc_step = {div_sh[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, lo[WIDTH-1:1]};
    end
    prod_fix = neg_q ? -acc_step : acc_step;
    quo_fix  = neg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    rem_fix  = neg_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
    if (!opt_q[2]) fin_res = (opt_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    else           fin_res = opt_q[1] ? rem_fix : quo_fix;
  end

  // FSM next state; flush overrides both handshakes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = fast ? S_DONE : S_BUSY;
      S_BUSY:  if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // FSM outputs.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    res       = res_q;
  end

  // Datapath next values: latch on accept, iterate in BUSY, capture the result on completion.
  always_comb begin
    opt_d = opt_q;
    neg_d = neg_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    opb_d = opb_q;
    res_d = res_q;
    if (state_q == S_IDLE && accept) begin
      opt_d = opt;
      // Remainder follows the dividend; product and quotient follow the sign mismatch.
      neg_d = (is_div && opt[1]) ? neg_a : (neg_a ^ neg_b);
      cnt_d = CNT_W'(WIDTH);
      acc_d = {{WIDTH{1'b0}}, abs_a};
      opb_d = abs_b;
      if (fast) res_d = fast_res;
    end else if (state_q == S_BUSY && !flush) begin
      acc_d = acc_step;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) res_d = fin_res;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      opt_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      opt_q   <= opt_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_ysyx_25040111_muldiv.sv
// Testbench for ysyx_25040111_muldiv (WIDTH=32).
// It runs directed cases, randomized operations checked against an arithmetic model,
// and backpressure, flush and reset-abort scenarios.
module tb_ysyx_25040111_muldiv;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [W-1:0] var1, var2, res;
  logic [2:0]   opt;

  int           n_chk = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];
  logic         mon_en = 1'b0;
  logic         saw_valid = 1'b0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
  } vec_t;

  vec_t dir_vecs[15] = '{
    '{3'd0, 32'hFFFFFFFF, 32'd7,        32'hFFFFFFF9},
    '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000},
    '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
    '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
    '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD},
    '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF},
    '{3'd5, 32'd100,      32'd7,        32'd14},
    '{3'd7, 32'd100,      32'd7,        32'd2},
    '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF},
    '{3'd7, 32'd5,        32'd0,        32'd5},
    '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
    '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000},
    '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF},
    '{3'd6, 32'd5,        32'd0,        32'd5},
    '{3'd3, 32'h80000000, 32'd2,        32'd1}
  };

  ysyx_25040111_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .var1      (var1),
    .var2      (var2),
    .opt       (opt),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res)
  );

  // Clock
  always #5 clock = ~clock;

  // Records any result that appears while monitoring an aborted operation.
  always @(negedge clock) begin
    if (mon_en && out_valid) saw_valid = 1'b1;
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: RISC-V M-extension results from plain 64-bit arithmetic.
  function automatic logic [W-1:0] ref_res(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    p   = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Cycles from the accepting edge until out_valid is first high.
  function automatic int ref_lat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
    return W + 1;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Driver: present a request, hold it through the accepting edge, then scramble the inputs.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    in_valid = 1'b1;
    opt      = op;
    var1     = a;
    var2     = b;
    @(posedge clock); #1;
    in_valid = 1'b0;
    opt      = 3'($urandom_range(0, 7));
    var1     = $urandom;
    var2     = $urandom;
  endtask

  // Wait for out_valid with a cycle budget, noting any in_ready seen while busy.
  task automatic wait_done(output int lat, output bit busy_rdy);
    lat      = 1;
    busy_rdy = 1'b0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready !== 1'b0) busy_rdy = 1'b1;
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_res, input string tag);
    int           lat;
    bit           busy_rdy;
    logic [W-1:0] e;
    exp_q.push_back(exp_res);
    send(op, a, b);
    wait_done(lat, busy_rdy);
    check({tag, "_lat"}, 64'(lat), 64'(ref_lat(op, a, b)));
    check({tag, "_busy_rdy"}, 64'(busy_rdy), 64'(0));
    e = exp_q.pop_front();
    check({tag, "_res"}, 64'(res), 64'(e));
    @(posedge clock); #1;
    check({tag, "_idle"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    int           lat;
    bit           busy_rdy, stable;
    logic [2:0]   op;
    logic [W-1:0] a, b, held;

    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    var1 = '0; var2 = '0; opt = '0;
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_res", 64'(res), 64'(0));

    // Directed vectors
    for (int i = 0; i < 15; i++)
      run_op(dir_vecs[i].op, dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].r, $sformatf("dir%0d", i));

    // Randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      run_op(op, a, b, ref_res(op, a, b), $sformatf("rand%0d_op%0d", i, op));
    end

    // Backpressure: the result must hold while out_ready is low
    out_ready = 1'b0;
    send(3'd0, 32'hFFFFFFFF, 32'd7);
    wait_done(lat, busy_rdy);
    check("bp_lat", 64'(lat), 64'(33));
    check("bp_res", 64'(res), 64'(32'hFFFFFFF9));
    held   = res;
    stable = 1'b1;
    repeat (10) begin
      @(posedge clock); #1;
      if (res !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    check("bp_stable", 64'(stable), 64'(1));
    @(negedge clock); out_ready = 1'b1;
    @(posedge clock); #1;
    check("bp_ready", 64'(in_ready), 64'(1));
    check("bp_ovalid", 64'(out_valid), 64'(0));
    check("bp_res_hold", 64'(res), 64'(32'hFFFFFFF9));

    // A request presented together with flush is not taken
    @(negedge clock);
    in_valid = 1'b1; flush = 1'b1; opt = 3'd4; var1 = 32'd9; var2 = 32'd0;
    @(posedge clock); #1;
    check("flush_noacc_rdy", 64'(in_ready), 64'(1));
    check("flush_noacc_ov", 64'(out_valid), 64'(0));
    @(negedge clock); in_valid = 1'b0; flush = 1'b0;

    // Flush mid-operation, then reset mid-operation: no result may appear
    mon_en    = 1'b1;
    saw_valid = 1'b0;
    send(3'd0, 32'd123, 32'd456);
    repeat (4) @(posedge clock);
    @(negedge clock); flush = 1'b1;
    @(posedge clock); #1;
    check("flush_idle", 64'(in_ready), 64'(1));
    @(negedge clock); flush = 1'b0;
    send(3'd4, 32'd1000, 32'd3);
    repeat (11) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    check("midrst_ready", 64'(in_ready), 64'(1));
    check("midrst_res", 64'(res), 64'(0));
    repeat (40) @(posedge clock);
    #1;
    mon_en = 1'b0;
    check("abort_no_valid", 64'(saw_valid), 64'(0));

    run_op(3'd0, 32'd3, 32'd4, 32'd12, "post_mul");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_25040111_muldiv.md
Name: ysyx_25040111_muldiv

Overview:
- Parametrised, multi-cycle integer multiply/divide unit; next generation of the single-cycle ALU.
- Covers the RV32M/RV64M operation set: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the ALU in the EXU.
- Uses valid/ready handshakes on both input and output, so the pipeline stalls while it iterates.

Parameters:
- WIDTH, 32: operand/result width in bits. Legal values are 32 and 64.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- var1  in  WIDTH  rs1 operand (multiplicand / dividend).
- var2  in  WIDTH  rs2 operand (multiplier / divisor).
- opt  in  3  operation (RISC-V funct3): 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- flush  in  1  abort any in-flight operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- res  out  WIDTH  result.

Behaviour:
- Reset: one clock and a synchronous active-high reset. On reset the FSM goes to IDLE and out_valid=0, res=0, in_ready=1. The counter and datapath registers are cleared.
- Reset mid-operation discards the operation; no result is produced.
- FSM has three states: IDLE, BUSY, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE -> BUSY on in_valid&&in_ready. On that edge, latch:
  - opt;
  - |var1| and |var2| according to signedness: MUL/MULH/DIV/REM signed both; MULHSU var1 signed, var2 unsigned; MULHU/DIVU/REMU unsigned;
  - the result sign;
  - counter = WIDTH.
- Fast path: IDLE -> DONE directly (out_valid on the next cycle) for:
  - divide by zero (var2==0 for opt 1xx): DIV/DIVU give all-ones; REM/REMU give var1.
  - signed overflow (var1 = most-negative, var2 = all-ones) for DIV/REM: DIV gives var1; REM gives 0.
- BUSY performs one iteration per cycle; the counter decrements each cycle. BUSY -> DONE when the counter reaches 1 on the current edge, so exactly WIDTH iterations run.
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, producing a WIDTH-bit quotient and remainder.
- Completion latency: out_valid is first high WIDTH+1 cycles after the accepting edge.
- Final sign fix-up is applied combinationally before the DONE register:
  - product negated if the operand signs differ (MULHSU: sign of var1 only);
  - quotient negated if the operand signs differ;
  - remainder takes the dividend's sign.
- Result selection: MUL returns the low WIDTH bits; MULH/MULHSU/MULHU the high WIDTH bits; DIV/DIVU the quotient; REM/REMU the remainder.
- Holding: in DONE, res and out_valid stay stable until out_valid&&out_ready. On that edge the FSM returns to IDLE. There is no back-to-back accept in the same cycle: in_ready stays 0 in DONE.
- Flush: flush=1 from any state forces IDLE on the next edge with out_valid=0.
  - flush takes priority over both handshakes.
  - A request presented with flush=1 is not accepted.
- Operand and opt changes after acceptance have no effect; inputs are sampled only on the accept edge.
- res is a register. When out_valid=0 it holds the last value (0 after reset).

Test Plan:
- WIDTH=32, MUL: var1=0xFFFFFFFF (-1), var2=7 -> res=0xFFFFFFF9. out_valid rises exactly 33 cycles after accept; in_ready=0 throughout.
- MULH -1*-1 -> 0x00000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). DIVU 100/7 -> 14. REMU 100/7 -> 2. Each completes in 33 cycles.
- Fast paths:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
  - Each fast path gives out_valid 1 cycle after accept.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> res stable, in_ready=0. Raise out_ready -> IDLE next cycle, in_ready=1.
- Flush at BUSY cycle 5, then reset at BUSY cycle 12 of a new op -> no out_valid ever. A new MUL 3*4 afterwards returns 12.
